// File: rtl/secded_decoder_pipe_if.sv
// Stream bundle for the SECDED decoder: codeword/tag in, decoded word with flags out.
interface secded_decoder_pipe_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  // Smallest r with 2^r >= DATA_W+r+1, valid for DATA_W in 4..247
  localparam int CHK_W  = (DATA_W <= 4)   ? 3 :
                          (DATA_W <= 11)  ? 4 :
                          (DATA_W <= 26)  ? 5 :
                          (DATA_W <= 57)  ? 6 :
                          (DATA_W <= 120) ? 7 : 8;
  localparam int CODE_W = DATA_W + CHK_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] in_code;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ce;
  logic              out_ue;
  logic [CHK_W-1:0]  out_syndrome;

  modport master (
    output in_valid, in_code, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_ce, out_ue, out_syndrome
  );

  modport slave (
    input  in_valid, in_code, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_ce, out_ue, out_syndrome
  );
endinterface

// File: rtl/secded_decoder_pipe.sv
// Two-stage SECDED decoder with valid/ready flow control, saturating CE/UE
// counters and a first-uncorrectable-error log.
module secded_decoder_pipe #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16,
  localparam int CHK_W  = (DATA_W <= 4)   ? 3 :
                          (DATA_W <= 11)  ? 4 :
                          (DATA_W <= 26)  ? 5 :
                          (DATA_W <= 57)  ? 6 :
                          (DATA_W <= 120) ? 7 : 8,
  localparam int CODE_W = DATA_W + CHK_W + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ecc_en,
  secded_decoder_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     ce_count,
  output logic [CNT_W-1:0]     ue_count,
  output logic                 log_valid,
  output logic [TAG_W-1:0]     log_tag,
  output logic [CHK_W-1:0]     log_syndrome
);

  // Positions covered by syndrome bit k: every position with bit k set
  function automatic logic [CODE_W-1:0] cover_mask(input int unsigned k);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int unsigned p = 1; p < CODE_W; p++) begin
      m[p] = ((p >> k) & 1) == 1;
    end
    return m;
  endfunction

  // Codeword position of data bit idx (data fills non-power-of-two slots from 3 upward)
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned n;
    int unsigned pos;
    n   = 0;
    pos = 0;
    for (int unsigned p = 3; p < 512; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic              s1_ecc;
  logic [CODE_W-1:0] s1_code;
  logic [TAG_W-1:0]  s1_tag;

  logic              s1_adv;
  logic              s2_adv;
  logic              xfer;

  logic [CHK_W-1:0]  syn;
  logic              par;
  logic [CODE_W-1:0] flip_sel;
  logic              in_range;
  logic [CODE_W-1:0] fixed;
  logic [DATA_W-1:0] dec_data;
  logic              dec_ce;
  logic              dec_ue;

  assign s2_adv       = ~bus.out_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;
  assign xfer         = bus.out_valid & bus.out_ready;

  // Stage 1: capture the raw codeword with the ecc_en value seen at acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ecc   <= 1'b0;
      s1_code  <= '0;
      s1_tag   <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ecc  <= ecc_en;
        s1_code <= bus.in_code;
        s1_tag  <= bus.in_tag;
      end
    end
  end

  for (genvar k = 0; k < CHK_W; k++) begin : g_syn
    localparam logic [CODE_W-1:0] MASK = cover_mask(k);
    assign syn[k] = ^(s1_code & MASK);
  end

  // One-hot of the position named by the syndrome; all-zero means it points past the codeword
  for (genvar p = 0; p < CODE_W; p++) begin : g_sel
    assign flip_sel[p] = (syn == CHK_W'(p));
  end

  assign par      = ^s1_code;
  assign in_range = |flip_sel;

  always_comb begin
    dec_ce = 1'b0;
    dec_ue = 1'b0;
    if (s1_ecc) begin
      if (par) begin
        if (in_range) dec_ce = 1'b1;
        else          dec_ue = 1'b1;
      end else if (syn != '0) begin
        dec_ue = 1'b1;
      end
    end
  end

  // A syndrome of 0 with odd parity selects bit 0, which carries no data
  assign fixed = s1_code ^ (flip_sel & {CODE_W{dec_ce}});

  for (genvar i = 0; i < DATA_W; i++) begin : g_ext
    localparam int unsigned POS = data_pos(i);
    assign dec_data[i] = fixed[POS];
  end

  // Stage 2: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid    <= 1'b0;
      bus.out_data     <= '0;
      bus.out_tag      <= '0;
      bus.out_ce       <= 1'b0;
      bus.out_ue       <= 1'b0;
      bus.out_syndrome <= '0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data     <= dec_data;
        bus.out_tag      <= s1_tag;
        bus.out_ce       <= dec_ce;
        bus.out_ue       <= dec_ue;
        bus.out_syndrome <= s1_ecc ? syn : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_count <= '0;
      ue_count <= '0;
    end else if (cnt_clr) begin
      ce_count <= '0;
      ue_count <= '0;
    end else begin
      if (xfer && bus.out_ce && (ce_count != '1)) ce_count <= ce_count + 1'b1;
      if (xfer && bus.out_ue && (ue_count != '1)) ue_count <= ue_count + 1'b1;
    end
  end

  // A UE transferring alongside cnt_clr starts a fresh log instead of being lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid    <= 1'b0;
      log_tag      <= '0;
      log_syndrome <= '0;
    end else if (xfer && bus.out_ue && (!log_valid || cnt_clr)) begin
      log_valid    <= 1'b1;
      log_tag      <= bus.out_tag;
      log_syndrome <= bus.out_syndrome;
    end else if (cnt_clr) begin
      log_valid    <= 1'b0;
      log_tag      <= '0;
      log_syndrome <= '0;
    end
  end

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.out_valid && bus.out_ce && bus.out_ue));

  a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_tag) &&
       $stable(bus.out_syndrome)));

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Scoreboard bench for secded_decoder_pipe (DATA_W=64, counters narrowed to 4 bits).
module tb_secded_decoder_pipe;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 8;
  localparam int CNT_W  = 4;
  localparam int CHK_W  = 7;
  localparam int CODE_W = 72;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  tag;
    logic        ce;
    logic        ue;
    logic [6:0]  syn;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ecc_en = 1'b1;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] ce_count;
  logic [CNT_W-1:0] ue_count;
  logic             log_valid;
  logic [TAG_W-1:0] log_tag;
  logic [CHK_W-1:0] log_syndrome;

  secded_decoder_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  secded_decoder_pipe #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ecc_en       (ecc_en),
    .bus          (bus),
    .cnt_clr      (cnt_clr),
    .ce_count     (ce_count),
    .ue_count     (ue_count),
    .log_valid    (log_valid),
    .log_tag      (log_tag),
    .log_syndrome (log_syndrome)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: syndrome is the XOR of the positions of all set bits
  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [71:0] c;
    int unsigned j;
    int unsigned s;
    c = '0;
    j = 0;
    s = 0;
    for (int unsigned p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[j];
        if (d[j]) s = s ^ p;
        j++;
      end
    end
    for (int unsigned k = 0; k < 7; k++) c[1 << k] = s[k];
    c[0] = ^c[71:1];
    return c;
  endfunction

  function automatic logic [63:0] extract(input logic [71:0] c);
    logic [63:0] d;
    int unsigned j;
    d = '0;
    j = 0;
    for (int unsigned p = 1; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = c[p];
        j++;
      end
    end
    return d;
  endfunction

  function automatic exp_t ref_decode(input logic [71:0] c, input logic [7:0] tag, input logic en);
    exp_t e;
    int unsigned s;
    int unsigned ones;
    logic [71:0] w;
    s = 0;
    ones = 0;
    for (int unsigned p = 0; p < 72; p++) begin
      if (c[p]) begin
        ones++;
        s = s ^ p;
      end
    end
    w = c;
    e.ce = 1'b0;
    e.ue = 1'b0;
    if (en) begin
      if (ones % 2 == 1) begin
        if (s < 72) begin
          e.ce = 1'b1;
          w[s] = ~w[s];
        end else begin
          e.ue = 1'b1;
        end
      end else if (s != 0) begin
        e.ue = 1'b1;
      end
    end
    e.data = extract(w);
    e.tag  = tag;
    e.syn  = en ? 7'(s) : 7'd0;
    return e;
  endfunction

  exp_t sb[$];
  exp_t e;
  int   m_ce = 0;
  int   m_ue = 0;
  logic m_lv = 1'b0;
  logic [7:0] m_lt = '0;
  logic [6:0] m_ls = '0;
  logic xf;

  // Monitor: checks flow control, pops expected words on transfers, tracks counters/log
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_ce = 0;
      m_ue = 0;
      m_lv = 1'b0;
      m_lt = '0;
      m_ls = '0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(sb.size() == 2 && !bus.out_ready)));
      chk("ce_count", 64'(ce_count), 64'(m_ce));
      chk("ue_count", 64'(ue_count), 64'(m_ue));
      chk("log_valid", 64'(log_valid), 64'(m_lv));
      chk("log_tag", 64'(log_tag), 64'(m_lt));
      chk("log_syndrome", 64'(log_syndrome), 64'(m_ls));
      xf = 1'b0;
      e  = '0;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got tag %0h with no word outstanding", bus.out_tag);
        end else begin
          e  = sb.pop_front();
          xf = 1'b1;
          chk("out_data", bus.out_data, e.data);
          chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
          chk("out_ce", 64'(bus.out_ce), 64'(e.ce));
          chk("out_ue", 64'(bus.out_ue), 64'(e.ue));
          chk("out_syndrome", 64'(bus.out_syndrome), 64'(e.syn));
        end
      end
      if (cnt_clr) begin
        m_ce = 0;
        m_ue = 0;
      end else begin
        if (xf && e.ce && m_ce < CNT_MAX) m_ce++;
        if (xf && e.ue && m_ue < CNT_MAX) m_ue++;
      end
      if (xf && e.ue && (!m_lv || cnt_clr)) begin
        m_lv = 1'b1;
        m_lt = e.tag;
        m_ls = e.syn;
      end else if (cnt_clr) begin
        m_lv = 1'b0;
        m_lt = '0;
        m_ls = '0;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(ref_decode(bus.in_code, bus.in_tag, ecc_en));
    end
  end

  logic rmode = 1'b0;
  logic rforce = 1'b1;

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rmode ? 1'($urandom_range(0, 1)) : rforce;
    end
  end

  task automatic send(input logic [71:0] code, input logic [7:0] tag, input logic en);
    logic acc;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_tag   = tag;
    ecc_en       = en;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: tag %0h never accepted", tag);
    end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !bus.out_valid;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding", sb.size());
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_ready(input logic mode, input logic val);
    rmode  = mode;
    rforce = val;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [63:0] w;
  logic [71:0] c;
  logic [71:0] cw;
  int unsigned pos;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.in_tag   = '0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", bus.out_data, 64'(0));
    chk("rst_out_tag", 64'(bus.out_tag), 64'(0));
    chk("rst_out_syndrome", 64'(bus.out_syndrome), 64'(0));
    chk("rst_ce_count", 64'(ce_count), 64'(0));
    chk("rst_ue_count", 64'(ue_count), 64'(0));
    chk("rst_log_valid", 64'(log_valid), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_ready(1'b0, 1'b1);
    set_ready(1'b0, 1'b1);

    w = 64'h0123_4567_89AB_CDEF;
    c = encode(w);
    send(c, 8'h11, 1'b1);
    chk("latency_s1", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("latency_s2", 64'(bus.out_valid), 64'(1));
    chk("clean_data", bus.out_data, w);
    chk("clean_tag", 64'(bus.out_tag), 64'(8'h11));

    cw = c;
    cw[3] = ~cw[3];
    send(cw, 8'h12, 1'b1);
    drain();
    chk("ce_after_bit3", 64'(ce_count), 64'(1));
    cw = c;
    cw[0] = ~cw[0];
    send(cw, 8'h13, 1'b1);
    drain();
    chk("ce_after_bit0", 64'(ce_count), 64'(2));

    cw = c;
    cw[5] = ~cw[5];
    cw[9] = ~cw[9];
    send(cw, 8'h2A, 1'b1);
    cw = c;
    cw[1] = ~cw[1];
    cw[2] = ~cw[2];
    send(cw, 8'h2B, 1'b1);
    drain();
    chk("ue_count_two", 64'(ue_count), 64'(2));
    chk("log_first_valid", 64'(log_valid), 64'(1));
    chk("log_first_tag", 64'(log_tag), 64'(8'h2A));
    chk("log_first_syn", 64'(log_syndrome), 64'(12));

    // Bypass: corrupted word passes through uncorrected with no flags
    cw = c;
    cw[20] = ~cw[20];
    send(cw, 8'h14, 1'b0);
    drain();
    chk("bypass_no_count", 64'(ce_count), 64'(2));

    set_ready(1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      w  = {$urandom, $urandom};
      cw = encode(w);
      for (int n = $urandom_range(0, 3); n > 0; n--) begin
        pos = $urandom_range(0, 71);
        cw[pos] = ~cw[pos];
      end
      send(cw, 8'(i), ($urandom_range(0, 9) != 0));
    end
    drain();

    @(posedge clk);
    #2;
    cnt_clr = 1'b1;
    @(posedge clk);
    #2;
    cnt_clr = 1'b0;
    cw = c;
    cw[40] = ~cw[40];
    cw[41] = ~cw[41];
    send(cw, 8'h30, 1'b1);
    for (int i = 0; i < 20; i++) begin
      w  = {$urandom, $urandom};
      cw = encode(w);
      pos = $urandom_range(0, 71);
      cw[pos] = ~cw[pos];
      send(cw, 8'(8'h80 + i), 1'b1);
    end
    drain();
    chk("ce_saturated", 64'(ce_count), 64'(CNT_MAX));
    chk("ue_after_clear", 64'(ue_count), 64'(1));
    chk("log_after_clear", 64'(log_tag), 64'(8'h30));

    set_ready(1'b0, 1'b0);
    cw = c;
    cw[10] = ~cw[10];
    send(cw, 8'h40, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = bus.out_valid;
      end
      chk("stall_out_valid", 64'(seen), 64'(1));
    end
    rforce = 1'b1;
    @(posedge clk);
    #2;
    cnt_clr = 1'b1;
    @(posedge clk);
    #2;
    cnt_clr = 1'b0;
    chk("clr_vs_ce_count", 64'(ce_count), 64'(0));
    chk("clr_log_valid", 64'(log_valid), 64'(0));
    drain();

    cw = c;
    cw[30] = ~cw[30];
    send(cw, 8'h50, 1'b1);
    drain();
    set_ready(1'b0, 1'b0);
    send(c, 8'h51, 1'b1);
    send(c, 8'h52, 1'b1);
    #1;
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_ce_count", 64'(ce_count), 64'(0));
    chk("async_ue_count", 64'(ue_count), 64'(0));
    chk("async_log_valid", 64'(log_valid), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_ready(1'b0, 1'b1);
    cw = c;
    cw[25] = ~cw[25];
    send(cw, 8'h60, 1'b1);
    drain();
    chk("post_reset_ce", 64'(ce_count), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
